cnet_dma_tx_engine: RTL
=======================

// Module: cnet_dma_tx_engine
// PURPOSE
//  CNET-side responder of the CNET->CPCI DMA transfer interface (nclk domain). Watches
//  per-queue packet availability and drives it to the CPCI as cpci_dma_pkt_avail.
//  Answers a cpci_dma_send request by streaming one packet: a byte-length word first,
//  then ceil(len/4) data words. Writes use cpci_dma_wr_en/cpci_dma_data and are
//  throttled by cpci_dma_nearly_full.
// PARAMETERS
//  NUM_Q      4    number of CNET packet queues (width of send/avail vectors)
//  DATA_W     32   DMA data word width
//  LEN_W      11   packet byte-length field width (max 2047 bytes)
// PORTS
//  nclk                  in   1            CNET clock; all logic on posedge
//  reset                 in   1            asynchronous, active-high
//  cpci_dma_send         in   NUM_Q        CPCI request: send packet from queue i (level)
//  cpci_dma_nearly_full  in   1            CPCI buffer cannot accept much more; stall reads
//  cpci_dma_pkt_avail    out  NUM_Q        queue i has a packet ready for CPCI
//  cpci_dma_wr_en        out  1            cpci_dma_data valid this cycle
//  cpci_dma_data         out  DATA_W       length word, then packet data
//  q_pkt_avail           in   NUM_Q        queue i holds a complete packet
//  q_pkt_len             in   NUM_Q*LEN_W  byte length of head packet, queue i at [i*LEN_W +: LEN_W]
//  q_rd_en               out  NUM_Q        pop one data word from queue i
//  q_rd_data             in   NUM_Q*DATA_W word from queue i, valid 1 cycle after q_rd_en
//  q_pkt_done            out  NUM_Q        1-cycle pulse: head packet of queue i fully consumed
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; word counter 0; sel cleared. Reset mid-transfer aborts
//   at once. No further q_rd_en and no q_pkt_done; the partial packet stays in its queue.
//  cpci_dma_pkt_avail = q_pkt_avail registered 1 cycle, with the bit of the queue in service
//   forced 0 from leaving IDLE until return to IDLE.
//  FSM states: IDLE -> LEN -> DATA -> DONE -> WAIT_REL -> IDLE.
//  IDLE: if any (cpci_dma_send & q_pkt_avail) bit is set, select the lowest set index as sel.
//   Latch len = q_pkt_len[sel] and words = (len+3)>>2, then go to LEN. Request bits whose
//   queue has no packet are ignored; stay IDLE.
//  LEN: when !cpci_dma_nearly_full, wr_en=1 and data = zero-extended len. Go to DATA, or to
//   DONE if words==0. While nearly_full is high, hold LEN with wr_en=0.
//  DATA: issue q_rd_en[sel] on each cycle with !nearly_full and issued<words. Read latency is
//   1 cycle, so wr_en/data follow each rd_en 1 cycle later, data = q_rd_data[sel].
//   nearly_full affects only new rd_en; a word already in flight is still written next cycle.
//   Go to DONE in the cycle the last word is written (written==words).
//  DONE: q_pkt_done[sel]=1 for exactly one cycle; go to WAIT_REL.
//  WAIT_REL: stay until cpci_dma_send[sel]==0 so a level request is not re-serviced; then IDLE.
//   Other send bits may stay high and are serviced from IDLE.
//  Requests arriving outside IDLE are ignored (not queued).
//  Counters are LEN_W-1 bits wide (enough for 2047/4 rounded up). No wrap is possible for
//   legal lengths.
//  At most one bit of q_rd_en and of q_pkt_done is set at any time. wr_en is never high
//   in IDLE, DONE or WAIT_REL.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, LEN, DATA, DONE, WAIT_REL) and the DMA length-word
//   format (len in [LEN_W-1:0], upper bits zero). The CPCI-side buffer uses the same format.
//  Sub-module: cnet_dma_q_sel. Priority encoder (lowest index) plus one-hot decode and
//   NUM_Q-way data/length mux. Everything else lives in the top.
// TESTING
//  1 Reset: q_pkt_avail=4'b0101 held during reset -> all outputs 0; one cycle after reset
//    release cpci_dma_pkt_avail=4'b0101.
//  2 Basic: q0 len=8, data 0xA0,0xA1; send=4'b0001 held until first wr_en -> writes 0x8, 0xA0,
//    0xA1 on 3 consecutive cycles. Then one q_pkt_done[0] pulse; pkt_avail[0] low throughout.
//  3 Odd length/zero length: len=5 -> length word 5 + 2 data words. Len=0 -> length word only,
//    no q_rd_en, q_pkt_done[0] still pulses.
//  4 Backpressure: len=2040 (510 words) with nearly_full toggling every 7 cycles -> exactly 511
//    writes, data in order, no q_rd_en while nearly_full is high, at most 1 write after it rises.
//  5 Arbitration/handshake: send=4'b1010, both avail -> queue 1 served first. Send[1] held high
//    after completion -> no second transfer of queue 1; queue 3 served once send[1] drops.
//  6 Abort: assert reset after 100 of 510 data words -> outputs 0 asynchronously, no
//    q_pkt_done; after release the packet is requested again and resent from its length word.

Source files
------------

// File: rtl/cnet_dma_tx_engine_pkg.sv
// rtl/cnet_dma_tx_engine_pkg.sv - shared FSM encoding and DMA length-word helpers
// Length word: byte length in [LEN_W-1:0], upper bits zero (same format on the CPCI side).
package cnet_dma_tx_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_DONE,
    ST_WAIT_REL
  } dma_state_e;

  function automatic int unsigned len_to_words(input int unsigned len);
    return (len + 32'd3) >> 2;
  endfunction

endpackage

// File: rtl/cnet_dma_q_sel.sv
// rtl/cnet_dma_q_sel.sv - lowest-index request picker plus one-hot decode and queue muxes
// o_len follows the picked request; o_data and o_sel_onehot follow i_sel.
module cnet_dma_q_sel
  import cnet_dma_tx_engine_pkg::*;
#(
  parameter int NUM_Q  = 4,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_Q-1:0]        i_req,
  input  logic [IDX_W-1:0]        i_sel,
  input  logic [NUM_Q*LEN_W-1:0]  i_len_bus,
  input  logic [NUM_Q*DATA_W-1:0] i_data_bus,
  output logic                    o_any,
  output logic [IDX_W-1:0]        o_idx,
  output logic [LEN_W-1:0]        o_len,
  output logic [NUM_Q-1:0]        o_sel_onehot,
  output logic [DATA_W-1:0]       o_data
);

  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_any = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    o_len        = '0;
    o_data       = '0;
    o_sel_onehot = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (IDX_W'(i) == o_idx) o_len = i_len_bus[i*LEN_W +: LEN_W];
      if (IDX_W'(i) == i_sel) begin
        o_data          = i_data_bus[i*DATA_W +: DATA_W];
        o_sel_onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnet_dma_tx_engine.sv
// rtl/cnet_dma_tx_engine.sv - CNET-side DMA responder: length word then packet words to CPCI
// The first queue read is issued alongside the length word so data follows back-to-back.
module cnet_dma_tx_engine
  import cnet_dma_tx_engine_pkg::*;
#(
  parameter int NUM_Q  = 4,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic                    nclk,
  input  logic                    reset,
  input  logic [NUM_Q-1:0]        cpci_dma_send,
  input  logic                    cpci_dma_nearly_full,
  output logic [NUM_Q-1:0]        cpci_dma_pkt_avail,
  output logic                    cpci_dma_wr_en,
  output logic [DATA_W-1:0]       cpci_dma_data,
  input  logic [NUM_Q-1:0]        q_pkt_avail,
  input  logic [NUM_Q*LEN_W-1:0]  q_pkt_len,
  output logic [NUM_Q-1:0]        q_rd_en,
  input  logic [NUM_Q*DATA_W-1:0] q_rd_data,
  output logic [NUM_Q-1:0]        q_pkt_done
);

  localparam int IDX_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
  localparam int CW    = LEN_W - 1;

  dma_state_e        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_sel, w_sel_nxt, w_pick_idx;
  logic [LEN_W-1:0]  r_len, w_pick_len;
  logic [CW-1:0]     r_words, r_issued, r_written;
  logic              r_inflight, w_any, w_rd, w_wr;
  logic [NUM_Q-1:0]  w_onehot, w_mask, r_avail;
  logic [DATA_W-1:0] w_rd_data;

  cnet_dma_q_sel #(
    .NUM_Q (NUM_Q),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W),
    .IDX_W (IDX_W)
  ) u_q_sel (
    .i_req       (cpci_dma_send & q_pkt_avail),
    .i_sel       (w_sel_nxt),
    .i_len_bus   (q_pkt_len),
    .i_data_bus  (q_rd_data),
    .o_any       (w_any),
    .o_idx       (w_pick_idx),
    .o_len       (w_pick_len),
    .o_sel_onehot(w_onehot),
    .o_data      (w_rd_data)
  );

  assign w_sel_nxt          = (r_state == ST_IDLE && w_any) ? w_pick_idx : r_sel;
  assign w_mask             = (w_state_nxt != ST_IDLE) ? w_onehot : '0;
  assign q_rd_en            = w_rd ? w_onehot : '0;
  assign cpci_dma_wr_en     = w_wr;
  assign cpci_dma_pkt_avail = r_avail;

  always_ff @(posedge nclk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rd          = 1'b0;
    w_wr          = 1'b0;
    cpci_dma_data = '0;
    q_pkt_done    = '0;
    case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = ST_LEN;
      ST_LEN: begin
        if (!cpci_dma_nearly_full) begin
          w_wr          = 1'b1;
          cpci_dma_data = DATA_W'(r_len);
          w_rd          = (r_words != '0);
          w_state_nxt   = (r_words == '0) ? ST_DONE : ST_DATA;
        end
      end
      ST_DATA: begin
        w_rd = !cpci_dma_nearly_full && (r_issued < r_words);
        w_wr = r_inflight;
        if (r_inflight) cpci_dma_data = w_rd_data;
        if (r_inflight && (r_written + CW'(1) == r_words)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        q_pkt_done  = w_onehot;
        w_state_nxt = ST_WAIT_REL;
      end
      ST_WAIT_REL: if (!(|(cpci_dma_send & w_onehot))) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Avail is masked using the next state so the serviced bit drops in the first LEN cycle.
  always_ff @(posedge nclk or posedge reset) begin
    if (reset) begin
      r_sel      <= '0;
      r_len      <= '0;
      r_words    <= '0;
      r_issued   <= '0;
      r_written  <= '0;
      r_inflight <= 1'b0;
      r_avail    <= '0;
    end else begin
      r_sel      <= w_sel_nxt;
      r_inflight <= w_rd;
      r_avail    <= q_pkt_avail & ~w_mask;
      if (r_state == ST_IDLE && w_any) begin
        r_len     <= w_pick_len;
        r_words   <= CW'(len_to_words(32'(w_pick_len)));
        r_issued  <= '0;
        r_written <= '0;
      end else begin
        if (w_rd) r_issued <= r_issued + CW'(1);
        if (w_wr && r_state == ST_DATA) r_written <= r_written + CW'(1);
      end
    end
  end

endmodule
